ascon_in_loader: RTL and testbench
==================================

// Module: ascon_in_loader
// PURPOSE
//  Parametrised input staging for the ASCON core: accepts a DW-bit valid/ready word stream tagged key/nonce/block.
//  Assembles each field MSB-word-first in a shadow register, then transfers it to the active register on a load strobe.
//  Per-field word counters, full flags, backpressure and load-error reporting.
//  Sits between the host/UART word interface and the permutation/control FSM.
// PARAMETERS
//  DW      32   input word width; must divide KEY_W, NONCE_W and BLK_W
//  KEY_W   128  key width
//  NONCE_W 128  nonce width
//  BLK_W   64   data block (rate) width; 128 for ASCON-128a
// PORTS
//  clk        in   1        clock, rising edge
//  rst        in   1        asynchronous reset, active-high
//  in_data    in   DW       input word
//  in_sel     in   2        word target: 0 key, 1 nonce, 2 block, 3 discard
//  in_valid   in   1        in_data/in_sel valid
//  in_ready   out  1        word accepted when in_valid & in_ready
//  flush      in   1        synchronous clear of shadows, counters and full flags
//  key_load   in   1        copy key shadow -> key output
//  nonce_load in   1        copy nonce shadow -> nonce output
//  blk_load   in   1        copy block shadow -> block output
//  key        out  KEY_W    active key
//  nonce      out  NONCE_W  active nonce
//  blk        out  BLK_W    active data block
//  key_full   out  1        key shadow complete, not yet transferred
//  nonce_full out  1        nonce shadow complete, not yet transferred
//  blk_full   out  1        block shadow complete, not yet transferred
//  blk_new    out  1        one-cycle pulse, cycle after a successful blk_load
//  load_err   out  1        one-cycle pulse: a load strobe hit a non-full shadow
// BEHAVIOUR
//  - Reset: all shadows, outputs, counters and full flags 0; in_ready 0 while rst is high; blk_new 0; load_err 0.
//  - Counters per field: NK=KEY_W/DW, NN=NONCE_W/DW, NB=BLK_W/DW words.
//    Word i (0-based) is written to bits [W-1-i*DW -: DW].
//  - Per-field fill FSM: FILL (cnt counts 0..N-1) -> FULL on the accepted word with cnt==N-1.
//    On that word cnt wraps to 0 and full is set next cycle.
//    FULL -> FILL only on a load of that field or on flush.
//  - in_ready (combinational):
//    in_sel=0 -> !key_full; in_sel=1 -> !nonce_full; in_sel=2 -> !blk_full; in_sel=3 -> 1 (word dropped, no state change).
//  - Load of field X with X_full=1: output register X <= shadow X at the clock edge; X_full cleared; shadow kept.
//  - Load of field X with X_full=0: output unchanged; load_err=1 next cycle.
//    Completing word and load in the same cycle counts as not full (error).
//  - Load of a full field and an accepted word to that field in the same cycle cannot occur, because in_ready=0 while full.
//  - Multiple load strobes in one cycle are handled independently; load_err if any one fails.
//  - blk_new=1 the cycle after a successful blk_load; one cycle only.
//  - flush: counters 0, full flags 0, shadows 0; outputs key/nonce/blk retained.
//    flush wins over a same-cycle accepted word and over loads (no transfer, no load_err).
//  - rst asserted mid-field: everything returns to reset; a partial field is lost, and the host restarts at word 0.
//  - Outputs are registered; they change only at a successful load edge, flush excepted.
// TESTING (DW=32, KEY_W=NONCE_W=128, BLK_W=64)
//  1. Key words 0x00010203, 0x04050607, 0x08090A0B, 0x0C0D0E0F with sel=0, then key_load
//     -> key = 0x000102030405060708090A0B0C0D0E0F; key_full 1 then 0.
//  2. Block words 0xDEADBEEF, 0x01234567, then a third block word with valid held
//     -> in_ready=0 and no accept; after blk_load, blk = 0xDEADBEEF01234567,
//     blk_new pulses once, and the third word is accepted.
//  3. blk_load after one block word -> load_err pulse; blk unchanged;
//     second word then blk_load -> success, no error.
//  4. Two nonce words then flush, then four words 0x11111111..0x44444444 and nonce_load
//     -> nonce = 0x11111111222222223333333344444444.
//  5. sel=3 words interleaved with key words -> in_ready=1, discards ignored, key assembled correctly;
//     then rst mid-key -> all outputs/flags 0.
//  6. Last block word and blk_load in the same cycle -> load_err, blk_full=1 next cycle;
//     repeat with BLK_W=128 -> 4-word block.

Source files
------------

// File: rtl/ascon_in_loader.sv
// ascon_in_loader: input staging for the ASCON core.
// Accepts a DW-bit valid/ready word stream tagged key/nonce/block/discard.
// Each field is assembled MSB-word-first in a shadow register and copied to
// its active register on a load strobe.
// Ports:
//   clk, rst                   clock (rising edge), async active-high reset
//   in_data, in_sel, in_valid  word stream (sel: 0 key, 1 nonce, 2 block, 3 drop)
//   in_ready                   combinational accept indication
//   flush                      sync clear of shadows, counters, full flags
//   key_load/nonce_load/blk_load  shadow -> active transfer strobes
//   key, nonce, blk            active registers
//   key_full/nonce_full/blk_full  shadow complete and not yet transferred
//   blk_new                    pulse the cycle after a successful blk_load
//   load_err                   pulse the cycle after a load of a non-full shadow

// One field: word counter, fill FSM, shadow and active register.
module ascon_in_field #(
  parameter int unsigned W  = 128,
  parameter int unsigned DW = 32
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          flush,
  input  logic          wr,
  input  logic [DW-1:0] data,
  input  logic          load,
  output logic [W-1:0]  active,
  output logic          full,
  output logic          load_ok_c,
  output logic          load_fail_c
);
  localparam int unsigned N  = W / DW;
  localparam int unsigned CW = (N > 1) ? $clog2(N) : 1;
  localparam logic [W-1:0] WORD_MASK = W'({DW{1'b1}});

  typedef enum logic {FILL = 1'b0, FULL = 1'b1} fill_state_t;

  fill_state_t   state, state_nxt;
  logic [CW-1:0] cnt, cnt_nxt;
  logic [W-1:0]  shadow, shadow_nxt;
  logic [W-1:0]  active_nxt;
  int unsigned   lo;

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= FILL;
      cnt    <= '0;
      shadow <= '0;
      active <= '0;
    end else begin
      state  <= state_nxt;
      cnt    <= cnt_nxt;
      shadow <= shadow_nxt;
      active <= active_nxt;
    end
  end

  // Next state: flush dominates; load judged on the pre-edge full state
  always_comb begin
    state_nxt   = state;
    cnt_nxt     = cnt;
    shadow_nxt  = shadow;
    active_nxt  = active;
    load_ok_c   = 1'b0;
    load_fail_c = 1'b0;
    // word i lands at bits [(N-1-i)*DW +: DW], i.e. MSB word first
    lo = (N - 1 - 32'(cnt)) * DW;
    if (flush) begin
      state_nxt  = FILL;
      cnt_nxt    = '0;
      shadow_nxt = '0;
    end else begin
      if (load) begin
        if (state == FULL) begin
          active_nxt = shadow;
          state_nxt  = FILL;
          load_ok_c  = 1'b1;
        end else begin
          load_fail_c = 1'b1;
        end
      end
      if (wr && state == FILL) begin
        shadow_nxt = (shadow & ~(WORD_MASK << lo)) | (W'(data) << lo);
        if (cnt == CW'(N - 1)) begin
          cnt_nxt   = '0;
          state_nxt = FULL;
        end else begin
          cnt_nxt = cnt + CW'(1);
        end
      end
    end
  end

  assign full = (state == FULL);
endmodule

module ascon_in_loader #(
  parameter int unsigned DW      = 32,
  parameter int unsigned KEY_W   = 128,
  parameter int unsigned NONCE_W = 128,
  parameter int unsigned BLK_W   = 64
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [DW-1:0]      in_data,
  input  logic [1:0]         in_sel,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic               flush,
  input  logic               key_load,
  input  logic               nonce_load,
  input  logic               blk_load,
  output logic [KEY_W-1:0]   key,
  output logic [NONCE_W-1:0] nonce,
  output logic [BLK_W-1:0]   blk,
  output logic               key_full,
  output logic               nonce_full,
  output logic               blk_full,
  output logic               blk_new,
  output logic               load_err
);
  logic accept;
  logic key_ok, nonce_ok, blk_ok;
  logic key_fail, nonce_fail, blk_fail;

  // Backpressure only toward a full target; discards always accepted
  always_comb begin
    in_ready = 1'b0;
    if (!rst) begin
      case (in_sel)
        2'd0:    in_ready = !key_full;
        2'd1:    in_ready = !nonce_full;
        2'd2:    in_ready = !blk_full;
        default: in_ready = 1'b1;
      endcase
    end
  end

  assign accept = in_valid && in_ready;

  ascon_in_field #(.W(KEY_W), .DW(DW)) u_key (
    .clk(clk), .rst(rst), .flush(flush),
    .wr(accept && in_sel == 2'd0), .data(in_data), .load(key_load),
    .active(key), .full(key_full), .load_ok_c(key_ok), .load_fail_c(key_fail)
  );

  ascon_in_field #(.W(NONCE_W), .DW(DW)) u_nonce (
    .clk(clk), .rst(rst), .flush(flush),
    .wr(accept && in_sel == 2'd1), .data(in_data), .load(nonce_load),
    .active(nonce), .full(nonce_full), .load_ok_c(nonce_ok), .load_fail_c(nonce_fail)
  );

  ascon_in_field #(.W(BLK_W), .DW(DW)) u_blk (
    .clk(clk), .rst(rst), .flush(flush),
    .wr(accept && in_sel == 2'd2), .data(in_data), .load(blk_load),
    .active(blk), .full(blk_full), .load_ok_c(blk_ok), .load_fail_c(blk_fail)
  );

  // Status pulses, one cycle after the load edge
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      blk_new  <= 1'b0;
      load_err <= 1'b0;
    end else begin
      blk_new  <= blk_ok;
      load_err <= key_fail || nonce_fail || blk_fail;
    end
  end

  logic unused_ok;
  assign unused_ok = key_ok ^ nonce_ok;
endmodule

// File: tb/tb_ascon_in_loader.sv
module tb_ascon_in_loader;
  logic         clk = 1'b0;
  logic         rst;
  logic [31:0]  in_data;
  logic [1:0]   in_sel;
  logic         in_valid, flush, key_load, nonce_load, blk_load;
  logic         in_ready, key_full, nonce_full, blk_full, blk_new, load_err;
  logic [127:0] key, nonce;
  logic [63:0]  blk;

  // 128-bit block instance (ASCON-128a rate)
  logic [31:0]  b_in_data;
  logic [1:0]   b_in_sel;
  logic         b_in_valid, b_flush, b_key_load, b_nonce_load, b_blk_load;
  logic         b_in_ready, b_key_full, b_nonce_full, b_blk_full, b_blk_new, b_load_err;
  logic [127:0] b_key, b_nonce, b_blk;

  int checks = 0;
  int failures = 0;

  logic [127:0] key_q[$];
  logic [127:0] nonce_q[$];
  logic [63:0]  blk_q[$];
  logic [127:0] b_blk_q[$];

  localparam logic [127:0] KEY1 = 128'h000102030405060708090A0B0C0D0E0F;

  always #5 clk = ~clk;

  ascon_in_loader #(.DW(32), .KEY_W(128), .NONCE_W(128), .BLK_W(64)) dut (
    .clk(clk), .rst(rst), .in_data(in_data), .in_sel(in_sel), .in_valid(in_valid),
    .in_ready(in_ready), .flush(flush), .key_load(key_load), .nonce_load(nonce_load),
    .blk_load(blk_load), .key(key), .nonce(nonce), .blk(blk), .key_full(key_full),
    .nonce_full(nonce_full), .blk_full(blk_full), .blk_new(blk_new), .load_err(load_err)
  );

  ascon_in_loader #(.DW(32), .KEY_W(128), .NONCE_W(128), .BLK_W(128)) dut128 (
    .clk(clk), .rst(rst), .in_data(b_in_data), .in_sel(b_in_sel), .in_valid(b_in_valid),
    .in_ready(b_in_ready), .flush(b_flush), .key_load(b_key_load), .nonce_load(b_nonce_load),
    .blk_load(b_blk_load), .key(b_key), .nonce(b_nonce), .blk(b_blk), .key_full(b_key_full),
    .nonce_full(b_nonce_full), .blk_full(b_blk_full), .blk_new(b_blk_new), .load_err(b_load_err)
  );

  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic put(input logic [1:0] s, input logic [31:0] d);
    in_sel = s; in_data = d; in_valid = 1'b1;
    cycle();
    in_valid = 1'b0;
  endtask

  task automatic load(input logic k, input logic n, input logic b);
    key_load = k; nonce_load = n; blk_load = b;
    cycle();
    key_load = 1'b0; nonce_load = 1'b0; blk_load = 1'b0;
  endtask

  task automatic b_put(input logic [31:0] d);
    b_in_sel = 2'd2; b_in_data = d; b_in_valid = 1'b1;
    cycle();
    b_in_valid = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; in_valid = 1'b1; in_sel = 2'd3;
    @(negedge clk);
    checks++; if (in_ready !== 1'b0) begin failures++; $display("FAIL reset_in_ready got=%b exp=0", in_ready); end
    checks++; if ({key, nonce, blk} !== '0) begin failures++; $display("FAIL reset_outputs got=%h %h %h exp=0", key, nonce, blk); end
    checks++; if ({key_full, nonce_full, blk_full, blk_new, load_err} !== 5'b0) begin
      failures++; $display("FAIL reset_flags got=%b exp=00000", {key_full, nonce_full, blk_full, blk_new, load_err}); end
    in_valid = 1'b0;
    cycle();
    rst = 1'b0;
    cycle();
  endtask

  task automatic test_key();
    logic [127:0] exp;
    put(2'd0, 32'h00010203); put(2'd0, 32'h04050607); put(2'd0, 32'h08090A0B);
    checks++; if (key_full !== 1'b0) begin failures++; $display("FAIL key_full_partial got=%b exp=0", key_full); end
    put(2'd0, 32'h0C0D0E0F);
    checks++; if (key_full !== 1'b1) begin failures++; $display("FAIL key_full_set got=%b exp=1", key_full); end
    in_sel = 2'd0; #1;
    checks++; if (in_ready !== 1'b0) begin failures++; $display("FAIL key_backpressure got=%b exp=0", in_ready); end
    key_q.push_back(KEY1);
    load(1'b1, 1'b0, 1'b0);
    exp = key_q.pop_front();
    checks++; if (key !== exp) begin failures++; $display("FAIL key_value got=%h exp=%h", key, exp); end
    checks++; if (key_full !== 1'b0) begin failures++; $display("FAIL key_full_clear got=%b exp=0", key_full); end
    checks++; if (load_err !== 1'b0) begin failures++; $display("FAIL key_load_err got=%b exp=0", load_err); end
  endtask

  task automatic test_backpressure();
    logic [63:0] exp;
    put(2'd2, 32'hDEADBEEF); put(2'd2, 32'h01234567);
    checks++; if (blk_full !== 1'b1) begin failures++; $display("FAIL bp_blk_full got=%b exp=1", blk_full); end
    in_sel = 2'd2; in_data = 32'hCAFEF00D; in_valid = 1'b1; #1;
    checks++; if (in_ready !== 1'b0) begin failures++; $display("FAIL bp_in_ready got=%b exp=0", in_ready); end
    cycle();
    checks++; if (blk_full !== 1'b1) begin failures++; $display("FAIL bp_held_full got=%b exp=1", blk_full); end
    blk_q.push_back(64'hDEADBEEF01234567);
    blk_load = 1'b1;
    cycle();
    blk_load = 1'b0;
    exp = blk_q.pop_front();
    checks++; if (blk !== exp) begin failures++; $display("FAIL bp_blk_value got=%h exp=%h", blk, exp); end
    checks++; if (blk_new !== 1'b1) begin failures++; $display("FAIL bp_blk_new got=%b exp=1", blk_new); end
    checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL bp_ready_after got=%b exp=1", in_ready); end
    cycle();
    in_valid = 1'b0;
    checks++; if (blk_new !== 1'b0) begin failures++; $display("FAIL bp_blk_new_once got=%b exp=0", blk_new); end
    put(2'd2, 32'h0BADC0DE);
    checks++; if (blk_full !== 1'b1) begin failures++; $display("FAIL bp_refill got=%b exp=1", blk_full); end
    blk_q.push_back(64'hCAFEF00D0BADC0DE);
    load(1'b0, 1'b0, 1'b1);
    exp = blk_q.pop_front();
    checks++; if (blk !== exp) begin failures++; $display("FAIL bp_held_word got=%h exp=%h", blk, exp); end
  endtask

  task automatic test_load_err();
    logic [63:0] exp;
    int n;
    flush = 1'b1; cycle(); flush = 1'b0;
    put(2'd2, 32'hAAAA5555);
    load(1'b0, 1'b0, 1'b1);
    checks++; if (load_err !== 1'b1) begin failures++; $display("FAIL err_pulse got=%b exp=1", load_err); end
    checks++; if (blk !== 64'hCAFEF00D0BADC0DE) begin failures++; $display("FAIL err_blk_kept got=%h exp=cafef00d0badc0de", blk); end
    checks++; if (blk_new !== 1'b0) begin failures++; $display("FAIL err_no_blk_new got=%b exp=0", blk_new); end
    cycle();
    checks++; if (load_err !== 1'b0) begin failures++; $display("FAIL err_one_cycle got=%b exp=0", load_err); end
    put(2'd2, 32'h12345678);
    blk_q.push_back(64'hAAAA555512345678);
    load(1'b0, 1'b0, 1'b1);
    checks++; if (load_err !== 1'b0) begin failures++; $display("FAIL err_ok_load got=%b exp=0", load_err); end
    n = 0;
    while (blk_new !== 1'b1 && n < 4) begin cycle(); n++; end
    checks++; if (n != 0) begin failures++; $display("FAIL err_blk_new_latency got=%0d exp=0", n); end
    exp = blk_q.pop_front();
    checks++; if (blk !== exp) begin failures++; $display("FAIL err_blk_value got=%h exp=%h", blk, exp); end
  endtask

  task automatic test_flush();
    logic [127:0] exp;
    put(2'd1, 32'hA0A0A0A0); put(2'd1, 32'hB0B0B0B0);
    flush = 1'b1; in_sel = 2'd1; in_data = 32'hDEADDEAD; in_valid = 1'b1; nonce_load = 1'b1;
    cycle();
    flush = 1'b0; in_valid = 1'b0; nonce_load = 1'b0;
    checks++; if (load_err !== 1'b0) begin failures++; $display("FAIL flush_no_err got=%b exp=0", load_err); end
    checks++; if (nonce !== 128'h0) begin failures++; $display("FAIL flush_nonce_out got=%h exp=0", nonce); end
    checks++; if (key !== KEY1) begin failures++; $display("FAIL flush_key_kept got=%h exp=%h", key, KEY1); end
    put(2'd1, 32'h11111111); put(2'd1, 32'h22222222); put(2'd1, 32'h33333333);
    checks++; if (nonce_full !== 1'b0) begin failures++; $display("FAIL flush_cnt_reset got=%b exp=0", nonce_full); end
    put(2'd1, 32'h44444444);
    checks++; if (nonce_full !== 1'b1) begin failures++; $display("FAIL flush_nonce_full got=%b exp=1", nonce_full); end
    nonce_q.push_back(128'h11111111222222223333333344444444);
    load(1'b0, 1'b1, 1'b0);
    exp = nonce_q.pop_front();
    checks++; if (nonce !== exp) begin failures++; $display("FAIL flush_nonce_value got=%h exp=%h", nonce, exp); end
  endtask

  task automatic test_discard();
    logic [1:0]   sels [8] = '{2'd0, 2'd3, 2'd0, 2'd3, 2'd0, 2'd3, 2'd3, 2'd0};
    logic [31:0]  dats [8] = '{32'hA1B2C3D4, 32'hFFFFFFFF, 32'h55667788, 32'h12121212,
                               32'h99AABBCC, 32'h0, 32'h77777777, 32'hDDEEFF00};
    logic [127:0] exp;
    for (int i = 0; i < 8; i++) begin
      in_sel = sels[i]; in_data = dats[i]; in_valid = 1'b1; #1;
      checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL disc_ready_%0d got=%b exp=1", i, in_ready); end
      cycle();
    end
    in_valid = 1'b0;
    checks++; if ({key_full, nonce_full, blk_full} !== 3'b100) begin
      failures++; $display("FAIL disc_flags got=%b exp=100", {key_full, nonce_full, blk_full}); end
    key_q.push_back(128'hA1B2C3D45566778899AABBCCDDEEFF00);
    load(1'b1, 1'b0, 1'b0);
    exp = key_q.pop_front();
    checks++; if (key !== exp) begin failures++; $display("FAIL disc_key got=%h exp=%h", key, exp); end
    put(2'd0, 32'h1); put(2'd0, 32'h2);
    rst = 1'b1; #1;
    checks++; if ({key, nonce, blk} !== '0) begin failures++; $display("FAIL rst_mid_outputs got=%h %h %h exp=0", key, nonce, blk); end
    checks++; if ({key_full, nonce_full, blk_full, blk_new, load_err, in_ready} !== 6'b0) begin
      failures++; $display("FAIL rst_mid_flags got=%b exp=000000", {key_full, nonce_full, blk_full, blk_new, load_err, in_ready}); end
    cycle();
    rst = 1'b0;
    cycle();
    put(2'd0, 32'h10101010); put(2'd0, 32'h20202020); put(2'd0, 32'h30303030);
    checks++; if (key_full !== 1'b0) begin failures++; $display("FAIL rst_restart_partial got=%b exp=0", key_full); end
    put(2'd0, 32'h40404040);
    key_q.push_back(128'h10101010202020203030303040404040);
    load(1'b1, 1'b0, 1'b0);
    exp = key_q.pop_front();
    checks++; if (key !== exp) begin failures++; $display("FAIL rst_restart_key got=%h exp=%h", key, exp); end
  endtask

  task automatic test_same_cycle();
    logic [63:0]  exp;
    logic [127:0] bexp;
    put(2'd2, 32'h13579BDF);
    in_sel = 2'd2; in_data = 32'h2468ACE0; in_valid = 1'b1; blk_load = 1'b1;
    cycle();
    in_valid = 1'b0; blk_load = 1'b0;
    checks++; if (load_err !== 1'b1) begin failures++; $display("FAIL same_err got=%b exp=1", load_err); end
    checks++; if (blk_full !== 1'b1) begin failures++; $display("FAIL same_full got=%b exp=1", blk_full); end
    checks++; if (blk !== 64'h0) begin failures++; $display("FAIL same_blk_kept got=%h exp=0", blk); end
    blk_q.push_back(64'h13579BDF2468ACE0);
    load(1'b0, 1'b0, 1'b1);
    exp = blk_q.pop_front();
    checks++; if (blk !== exp) begin failures++; $display("FAIL same_blk_value got=%h exp=%h", blk, exp); end
    // 4-word block variant
    b_put(32'h01010101); b_put(32'h02020202); b_put(32'h03030303);
    checks++; if (b_blk_full !== 1'b0) begin failures++; $display("FAIL b128_partial got=%b exp=0", b_blk_full); end
    b_in_data = 32'h04040404; b_in_valid = 1'b1; b_blk_load = 1'b1;
    cycle();
    b_in_valid = 1'b0; b_blk_load = 1'b0;
    checks++; if (b_load_err !== 1'b1) begin failures++; $display("FAIL b128_err got=%b exp=1", b_load_err); end
    checks++; if (b_blk_full !== 1'b1) begin failures++; $display("FAIL b128_full got=%b exp=1", b_blk_full); end
    b_blk_q.push_back(128'h01010101020202020303030304040404);
    b_blk_load = 1'b1; cycle(); b_blk_load = 1'b0;
    bexp = b_blk_q.pop_front();
    checks++; if (b_blk !== bexp) begin failures++; $display("FAIL b128_value got=%h exp=%h", b_blk, bexp); end
    checks++; if (b_blk_new !== 1'b1) begin failures++; $display("FAIL b128_blk_new got=%b exp=1", b_blk_new); end
    checks++; if ({b_key, b_nonce, b_key_full, b_nonce_full, b_in_ready} !== {256'h0, 3'b001}) begin
      failures++; $display("FAIL b128_idle got=%h %h %b exp=0 0 001", b_key, b_nonce, {b_key_full, b_nonce_full, b_in_ready}); end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end

  initial begin
    rst = 1'b1; in_data = '0; in_sel = '0; in_valid = 1'b0; flush = 1'b0;
    key_load = 1'b0; nonce_load = 1'b0; blk_load = 1'b0;
    b_in_data = '0; b_in_sel = 2'd2; b_in_valid = 1'b0; b_flush = 1'b0;
    b_key_load = 1'b0; b_nonce_load = 1'b0; b_blk_load = 1'b0;
    test_reset();
    test_key();
    test_backpressure();
    test_load_err();
    test_flush();
    test_discard();
    test_same_cycle();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
